turn_sched: RTL and testbench

//  Two-player turn controller between the keypad scanner and the board/game logic.

---
 rtl/turn_pkg.sv | 29 ++
 rtl/turn_sched_if.sv | 33 +++
 rtl/turn_timer.sv | 32 +++
 rtl/turn_sched.sv | 150 +++++++++++++++
 tb/tb_turn_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the two-player turn controller: FSM state
// encoding, keypad code constants and small key-decoding helpers.
package turn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ARMED  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam logic [3:0] KEY_CANCEL  = 4'd10;
   localparam logic [3:0] KEY_CONFIRM = 4'd11;
   localparam logic [3:0] CELL_MIN    = 4'd1;
   localparam logic [3:0] CELL_MAX    = 4'd9;

   // True when the key code names a board cell (1..9).
   function automatic logic is_cell(input logic [3:0] code);
      return (code >= CELL_MIN) && (code <= CELL_MAX);
   endfunction

   // Occupancy bit for cell 'code' (bit code-1). Only meaningful for cell codes.
   function automatic logic cell_taken(input logic [3:0] code, input logic [8:0] occ);
      logic [8:0] sh;
      sh = occ >> (code - CELL_MIN);
      return sh[0];
   endfunction

endpackage

// File: rtl/turn_sched_if.sv
// Bundle between keypad scanner / board logic (master side) and turn_sched
// (slave side).
// key_valid is a level from the scanner: only its rising edge is a press,
// key_code is taken in that same cycle, and holding key_valid high never
// produces a second press. There is no back-pressure; en, skip and err are
// single-cycle strobes the board side must take when they occur.
interface turn_sched_if;
   import turn_pkg::*;

   logic [3:0] key_code;
   logic       key_valid;
   logic [8:0] occ;
   logic       game_over;
   logic       en;
   logic       whose;
   logic [3:0] pos;
   logic       armed;
   logic       skip;
   logic       err;
   logic       active;
   state_t     dbg_state;

   modport master (
      output key_code, key_valid, occ, game_over,
      input  en, whose, pos, armed, skip, err, active, dbg_state
   );

   modport slave (
      input  key_code, key_valid, occ, game_over,
      output en, whose, pos, armed, skip, err, active, dbg_state
   );

endinterface

// File: rtl/turn_timer.sv
// Per-turn countdown. Counts while run is high, returns to zero when
// cleared or on the cycle after expiry, so a new turn always starts at 0.
module turn_timer #(
   parameter int CNT_W      = 32,
   parameter int TURN_TICKS = 500_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TURN_TICKS - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   assign expire = run & (cnt == LAST);

   // Turn counter: cleared outside active turns and after each expiry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || expire) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/turn_sched.sv
// Two-player turn controller: turns scanner presses into cell selection,
// confirm commits and per-turn timeouts for the board and win detector.
module turn_sched
   import turn_pkg::*;
#(
   parameter int TURN_TICKS = 500_000_000,
   parameter int CNT_W      = 32
) (
   input  logic         clk,
   input  logic         rst,
   turn_sched_if.slave  bus
);

   state_t     state;
   logic       valid_q;
   logic       ev;
   logic [3:0] code_q;
   logic [8:0] occ_q;
   logic       expire;
   logic       run;
   logic       en_r;
   logic       whose_r;
   logic [3:0] pos_r;
   logic       skip_r;
   logic       err_r;
   logic       ev_cell;
   logic       ev_free;

   // Press detector: one registered event per rising edge of key_valid,
   // with code and occupancy captured alongside it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         ev      <= 1'b0;
         code_q  <= 4'd0;
         occ_q   <= 9'd0;
      end else begin
         valid_q <= bus.key_valid;
         ev      <= bus.key_valid & ~valid_q;
         code_q  <= bus.key_code;
         occ_q   <= bus.occ;
      end
   end

   assign ev_cell = ev & is_cell(code_q);
   assign ev_free = ~cell_taken(code_q, occ_q);

   // The clock only runs while a player is choosing; COMMIT and IDLE hold it at 0.
   assign run = (state == ST_SELECT) || (state == ST_ARMED);

   turn_timer #(
      .CNT_W      (CNT_W),
      .TURN_TICKS (TURN_TICKS)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (~run),
      .run    (run),
      .expire (expire)
   );

   // Turn FSM with registered strobes. Priority in ARMED: game_over,
   // then confirm (beats a coincident timeout), then timeout, then other keys.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         en_r    <= 1'b0;
         whose_r <= 1'b0;
         pos_r   <= 4'd0;
         skip_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         en_r   <= 1'b0;
         skip_r <= 1'b0;
         err_r  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ev && (code_q == KEY_CONFIRM) && !bus.game_over) begin
                  state   <= ST_SELECT;
                  whose_r <= 1'b0;
                  pos_r   <= 4'd0;
               end
            end
            ST_SELECT: begin
               if (bus.game_over) begin
                  state <= ST_IDLE;
                  pos_r <= 4'd0;
               end else if (expire) begin
                  skip_r  <= 1'b1;
                  whose_r <= ~whose_r;
                  pos_r   <= 4'd0;
               end else if (ev_cell) begin
                  if (ev_free) begin
                     state <= ST_ARMED;
                     pos_r <= code_q;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            ST_ARMED: begin
               if (bus.game_over) begin
                  state <= ST_IDLE;
                  pos_r <= 4'd0;
               end else if (ev && (code_q == KEY_CONFIRM)) begin
                  state <= ST_COMMIT;
                  en_r  <= 1'b1;
               end else if (expire) begin
                  state   <= ST_SELECT;
                  skip_r  <= 1'b1;
                  whose_r <= ~whose_r;
                  pos_r   <= 4'd0;
               end else if (ev_cell) begin
                  if (ev_free) begin
                     pos_r <= code_q;
                  end else begin
                     err_r <= 1'b1;
                  end
               end else if (ev && (code_q == KEY_CANCEL)) begin
                  state <= ST_SELECT;
                  pos_r <= 4'd0;
               end
            end
            ST_COMMIT: begin
               pos_r <= 4'd0;
               if (bus.game_over) begin
                  state <= ST_IDLE;
               end else begin
                  state   <= ST_SELECT;
                  whose_r <= ~whose_r;
               end
            end
            default: begin
               state <= ST_IDLE;
               pos_r <= 4'd0;
            end
         endcase
      end
   end

   assign bus.en        = en_r;
   assign bus.whose     = whose_r;
   assign bus.pos       = pos_r;
   assign bus.skip      = skip_r;
   assign bus.err       = err_r;
   assign bus.armed     = (state == ST_ARMED);
   assign bus.active    = (state != ST_IDLE);
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_turn_sched.sv
// Directed bench for turn_sched with TURN_TICKS = 20. Commits are
// scoreboarded: the expected {whose,pos} is queued when '#' is driven and
// popped when en is seen.
module tb_turn_sched;
   import turn_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   en_cnt;
   int   skip_cnt;
   int   err_cnt;
   logic [4:0] exp_q[$];

   turn_sched_if bus ();

   turn_sched #(
      .TURN_TICKS (20),
      .CNT_W      (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sampling point: just after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic press_hold(input logic [3:0] code, input int hold);
      step();
      bus.key_code  = code;
      bus.key_valid = 1'b1;
      repeat (hold) step();
      bus.key_valid = 1'b0;
      step();
   endtask

   task automatic press(input logic [3:0] code);
      press_hold(code, 1);
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.occ       = 9'd0;
      bus.game_over = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},     32'(bus.en),     0);
      chk({tag, "_whose"},  32'(bus.whose),  0);
      chk({tag, "_pos"},    32'(bus.pos),    0);
      chk({tag, "_armed"},  32'(bus.armed),  0);
      chk({tag, "_skip"},   32'(bus.skip),   0);
      chk({tag, "_err"},    32'(bus.err),    0);
      chk({tag, "_active"}, 32'(bus.active), 0);
   endtask

   // Scoreboard / pulse monitor
   always @(negedge clk) begin
      if (rst) begin
         if (bus.en) begin
            en_cnt++;
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               logic [4:0] e;
               e = exp_q.pop_front();
               chk("sb_commit", 32'({bus.whose, bus.pos}), 32'(e));
            end
         end
         if (bus.skip) skip_cnt++;
         if (bus.err)  err_cnt++;
      end
   end

   initial begin
      int n0;
      total    = 0;
      bad      = 0;
      en_cnt   = 0;
      skip_cnt = 0;
      err_cnt  = 0;

      // 1. reset, start, select 5, commit
      rst = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.occ       = 9'd0;
      bus.game_over = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b1;
      press(KEY_CONFIRM);
      chk("t1_active", 32'(bus.active), 1);
      chk("t1_state_sel", 32'(bus.dbg_state), 32'(ST_SELECT));
      press(4'd5);
      chk("t1_armed", 32'(bus.armed), 1);
      chk("t1_pos5", 32'(bus.pos), 5);
      exp_q.push_back({1'b0, 4'd5});
      press(KEY_CONFIRM);
      chk("t1_en", 32'(bus.en), 1);
      chk("t1_en_pos", 32'(bus.pos), 5);
      step();
      chk("t1_en_gone", 32'(bus.en), 0);
      chk("t1_whose1", 32'(bus.whose), 1);
      chk("t1_pos0", 32'(bus.pos), 0);
      chk("t1_en_cnt", 32'(en_cnt), 1);

      // 2. occupied cell, reselect, cancel
      do_reset();
      bus.occ = 9'b000010000;
      press(KEY_CONFIRM);
      n0 = err_cnt;
      press(4'd5);
      chk("t2_err", 32'(bus.err), 1);
      chk("t2_not_armed", 32'(bus.armed), 0);
      step();
      chk("t2_err_pulse", 32'(bus.err), 0);
      chk("t2_err_cnt", 32'(err_cnt - n0), 1);
      press(4'd3);
      chk("t2_pos3", 32'(bus.pos), 3);
      press(4'd7);
      chk("t2_pos7", 32'(bus.pos), 7);
      chk("t2_armed7", 32'(bus.armed), 1);
      press(KEY_CANCEL);
      chk("t2_cancel_pos", 32'(bus.pos), 0);
      chk("t2_cancel_armed", 32'(bus.armed), 0);
      chk("t2_cancel_active", 32'(bus.active), 1);

      // 3. idle timeout in SELECT
      do_reset();
      press(KEY_CONFIRM);
      n0 = en_cnt;
      repeat (19) step();
      chk("t3_no_skip_early", 32'(bus.skip), 0);
      chk("t3_skip_cnt0", 32'(skip_cnt), 0);
      step();
      chk("t3_skip", 32'(bus.skip), 1);
      chk("t3_whose", 32'(bus.whose), 1);
      chk("t3_no_en", 32'(en_cnt - n0), 0);
      step();
      chk("t3_skip_pulse", 32'(bus.skip), 0);

      // 4. '#' coincident with last timer tick: commit wins
      do_reset();
      press(KEY_CONFIRM);
      press(4'd2);
      n0 = skip_cnt;
      repeat (14) step();
      exp_q.push_back({1'b0, 4'd2});
      press(KEY_CONFIRM);
      chk("t4_en", 32'(bus.en), 1);
      chk("t4_skip", 32'(bus.skip), 0);
      step();
      chk("t4_whose", 32'(bus.whose), 1);
      chk("t4_skip_cnt", 32'(skip_cnt - n0), 0);

      // 5. held keys act once
      do_reset();
      press(KEY_CONFIRM);
      n0 = err_cnt;
      press_hold(4'd4, 10);
      chk("t5_pos4", 32'(bus.pos), 4);
      chk("t5_armed", 32'(bus.armed), 1);
      chk("t5_no_err", 32'(err_cnt - n0), 0);
      n0 = en_cnt;
      exp_q.push_back({1'b0, 4'd4});
      press_hold(KEY_CONFIRM, 10);
      chk("t5_one_en", 32'(en_cnt - n0), 1);
      chk("t5_whose", 32'(bus.whose), 1);
      chk("t5_state_sel", 32'(bus.dbg_state), 32'(ST_SELECT));

      // 6. game_over during COMMIT, then reset mid-turn
      do_reset();
      press(KEY_CONFIRM);
      press(4'd6);
      exp_q.push_back({1'b0, 4'd6});
      press(KEY_CONFIRM);
      chk("t6_en", 32'(bus.en), 1);
      bus.game_over = 1'b1;
      step();
      chk("t6_idle", 32'(bus.active), 0);
      chk("t6_whose_held", 32'(bus.whose), 0);
      chk("t6_pos0", 32'(bus.pos), 0);
      press(KEY_CONFIRM);
      chk("t6_go_ignores_start", 32'(bus.active), 0);
      bus.game_over = 1'b0;
      press(KEY_CONFIRM);
      press(4'd8);
      chk("t6_armed", 32'(bus.armed), 1);
      n0 = en_cnt + skip_cnt;
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("t6_async_rst");
      step();
      rst = 1'b1;
      step();
      chk("t6_rst_idle", 32'(bus.active), 0);
      chk("t6_no_strobes", 32'(en_cnt + skip_cnt - n0), 0);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
